// File: rtl/ex_mem_stage.sv
// ex_mem_stage: execute stage plus the EX/MEM pipeline register.
// Operand forwarding and the ALU are combinational. Results, store data,
// the destination register and the WB/MEM control bits are registered for
// the MEM stage. The register supports stall (hold) and flush (bubble).
// Optional feature macro: EX_FWD_EN enables operand forwarding from the
// EX/MEM register and from the MEM/WB stage. When it is undefined, the
// register-file values are used unchanged.
module ex_mem_stage #(
    parameter int XLEN    = 32,
    parameter int ALUOP_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               EX_MEM_Write,
    input  logic               EX_Flush,
    input  logic [XLEN-1:0]    ID_EX_PC,
    input  logic [XLEN-1:0]    ID_EX_read1_data,
    input  logic [XLEN-1:0]    ID_EX_read2_data,
    input  logic [63:0]        ID_EX_imm,
    input  logic [4:0]         ID_EX_RS1,
    input  logic [4:0]         ID_EX_RS2,
    input  logic [4:0]         ID_EX_RD,
    input  logic               ID_EX_RegWrite,
    input  logic               ID_EX_MemtoReg,
    input  logic               ID_EX_MemWrite,
    input  logic               ID_EX_MemRead,
    input  logic               ID_EX_Branch,
    input  logic               ID_EX_ALUSrc,
    input  logic [ALUOP_W-1:0] ID_EX_ALUOp,
    input  logic               MEM_WB_RegWrite,
    input  logic [4:0]         MEM_WB_RD,
    input  logic [XLEN-1:0]    MEM_WB_wdata,
    output logic [XLEN-1:0]    EX_MEM_ALU_result,
    output logic               EX_MEM_Zero,
    output logic [XLEN-1:0]    EX_MEM_BrTarget,
    output logic [XLEN-1:0]    EX_MEM_wdata,
    output logic [4:0]         EX_MEM_RD,
    output logic               EX_MEM_RegWrite,
    output logic               EX_MEM_MemtoReg,
    output logic               EX_MEM_MemWrite,
    output logic               EX_MEM_MemRead,
    output logic               EX_MEM_Branch
);

    localparam logic [ALUOP_W-1:0] OP_ADD   = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] OP_SUB   = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] OP_AND   = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] OP_OR    = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] OP_XOR   = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] OP_SLL   = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] OP_SRL   = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] OP_SRA   = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] OP_SLT   = ALUOP_W'(8);
    localparam logic [ALUOP_W-1:0] OP_SLTU  = ALUOP_W'(9);
    localparam logic [ALUOP_W-1:0] OP_PASSB = ALUOP_W'(10);

    logic [XLEN-1:0] alu_result_q, alu_result_d;
    logic            zero_q, zero_d;
    logic [XLEN-1:0] br_target_q, br_target_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [4:0]      rd_q, rd_d;
    logic            reg_write_q, reg_write_d;
    logic            memto_reg_q, memto_reg_d;
    logic            mem_write_q, mem_write_d;
    logic            mem_read_q, mem_read_d;
    logic            branch_q, branch_d;

    logic [XLEN-1:0] op_a, fwd_b, op_b, alu_res, imm_x;
    logic [4:0]      shamt;

    assign imm_x = ID_EX_imm[XLEN-1:0];

    // Immediate bits above XLEN carry no information for this datapath.
    if (XLEN < 64) begin : g_imm_hi
        logic unused_imm_hi;
        assign unused_imm_hi = ^ID_EX_imm[63:XLEN];
    end

`ifdef EX_FWD_EN
    // Pick the newest value for a source register; the EX/MEM result wins
    // over MEM/WB, loads in EX/MEM are skipped, and x0 is never forwarded.
    function automatic logic [XLEN-1:0] fwd_sel(input logic [4:0] rs,
                                                input logic [XLEN-1:0] raw);
        logic [XLEN-1:0] v;
        v = raw;
        if (reg_write_q && !memto_reg_q && rd_q != 5'd0 && rd_q == rs)
            v = alu_result_q;
        else if (MEM_WB_RegWrite && MEM_WB_RD != 5'd0 && MEM_WB_RD == rs)
            v = MEM_WB_wdata;
        return v;
    endfunction

    // Forwarded source operands.
    always_comb begin
        op_a  = fwd_sel(ID_EX_RS1, ID_EX_read1_data);
        fwd_b = fwd_sel(ID_EX_RS2, ID_EX_read2_data);
    end
`else
    // Without forwarding the register-file values feed the ALU directly.
    always_comb begin
        op_a  = ID_EX_read1_data;
        fwd_b = ID_EX_read2_data;
    end

    logic unused_fwd;
    assign unused_fwd = ^{ID_EX_RS1, ID_EX_RS2, MEM_WB_RegWrite, MEM_WB_RD, MEM_WB_wdata};
`endif

    assign op_b  = ID_EX_ALUSrc ? imm_x : fwd_b;
    assign shamt = op_b[4:0];

    // ALU: undefined opcodes produce 0.
    always_comb begin
        alu_res = '0;
        case (ID_EX_ALUOp)
            OP_ADD:   alu_res = op_a + op_b;
            OP_SUB:   alu_res = op_a - op_b;
            OP_AND:   alu_res = op_a & op_b;
            OP_OR:    alu_res = op_a | op_b;
            OP_XOR:   alu_res = op_a ^ op_b;
            OP_SLL:   alu_res = op_a << shamt;
            OP_SRL:   alu_res = op_a >> shamt;
            OP_SRA:   alu_res = $unsigned($signed(op_a) >>> shamt);
            OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            OP_PASSB: alu_res = op_b;
            default:  alu_res = '0;
        endcase
    end

    // Next register contents: flush beats hold, hold beats load.
    always_comb begin
        alu_result_d = alu_result_q;
        zero_d       = zero_q;
        br_target_d  = br_target_q;
        wdata_d      = wdata_q;
        rd_d         = rd_q;
        reg_write_d  = reg_write_q;
        memto_reg_d  = memto_reg_q;
        mem_write_d  = mem_write_q;
        mem_read_d   = mem_read_q;
        branch_d     = branch_q;
        if (EX_Flush) begin
            alu_result_d = '0;
            zero_d       = 1'b0;
            br_target_d  = '0;
            wdata_d      = '0;
            rd_d         = 5'd0;
            reg_write_d  = 1'b0;
            memto_reg_d  = 1'b0;
            mem_write_d  = 1'b0;
            mem_read_d   = 1'b0;
            branch_d     = 1'b0;
        end else if (EX_MEM_Write) begin
            alu_result_d = alu_res;
            zero_d       = (alu_res == '0);
            br_target_d  = ID_EX_PC + imm_x;
            wdata_d      = fwd_b;
            rd_d         = ID_EX_RD;
            reg_write_d  = ID_EX_RegWrite;
            memto_reg_d  = ID_EX_MemtoReg;
            mem_write_d  = ID_EX_MemWrite;
            mem_read_d   = ID_EX_MemRead;
            branch_d     = ID_EX_Branch;
        end
    end

    // EX/MEM pipeline register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_result_q <= '0;
            zero_q       <= 1'b0;
            br_target_q  <= '0;
            wdata_q      <= '0;
            rd_q         <= 5'd0;
            reg_write_q  <= 1'b0;
            memto_reg_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            branch_q     <= 1'b0;
        end else begin
            alu_result_q <= alu_result_d;
            zero_q       <= zero_d;
            br_target_q  <= br_target_d;
            wdata_q      <= wdata_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            memto_reg_q  <= memto_reg_d;
            mem_write_q  <= mem_write_d;
            mem_read_q   <= mem_read_d;
            branch_q     <= branch_d;
        end
    end

    assign EX_MEM_ALU_result = alu_result_q;
    assign EX_MEM_Zero       = zero_q;
    assign EX_MEM_BrTarget   = br_target_q;
    assign EX_MEM_wdata      = wdata_q;
    assign EX_MEM_RD         = rd_q;
    assign EX_MEM_RegWrite   = reg_write_q;
    assign EX_MEM_MemtoReg   = memto_reg_q;
    assign EX_MEM_MemWrite   = mem_write_q;
    assign EX_MEM_MemRead    = mem_read_q;
    assign EX_MEM_Branch     = branch_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Testbench for ex_mem_stage: directed steps, scoreboard queue of expected
// EX/MEM contents, immediate-assertion comparisons.
module tb_ex_mem_stage;

`ifdef EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] alu;
        logic        zero;
        logic [31:0] br;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic        rw;
        logic        m2r;
        logic        mw;
        logic        mr;
        logic        brn;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr, fl;
    logic [31:0] pc, r1, r2;
    logic [63:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic        c_rw, c_m2r, c_mw, c_mr, c_br, c_src;
    logic [4:0]  aluop;
    logic        wb_rw;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    logic [31:0] o_alu, o_br, o_wdata;
    logic        o_zero, o_rw, o_m2r, o_mw, o_mr, o_brn;
    logic [4:0]  o_rd;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t cur;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    ex_mem_stage #(.XLEN(32), .ALUOP_W(5)) dut (
        .clk(clk), .rst(rst), .EX_MEM_Write(wr), .EX_Flush(fl),
        .ID_EX_PC(pc), .ID_EX_read1_data(r1), .ID_EX_read2_data(r2),
        .ID_EX_imm(imm), .ID_EX_RS1(rs1), .ID_EX_RS2(rs2), .ID_EX_RD(rd),
        .ID_EX_RegWrite(c_rw), .ID_EX_MemtoReg(c_m2r), .ID_EX_MemWrite(c_mw),
        .ID_EX_MemRead(c_mr), .ID_EX_Branch(c_br), .ID_EX_ALUSrc(c_src),
        .ID_EX_ALUOp(aluop), .MEM_WB_RegWrite(wb_rw), .MEM_WB_RD(wb_rd),
        .MEM_WB_wdata(wb_data),
        .EX_MEM_ALU_result(o_alu), .EX_MEM_Zero(o_zero), .EX_MEM_BrTarget(o_br),
        .EX_MEM_wdata(o_wdata), .EX_MEM_RD(o_rd), .EX_MEM_RegWrite(o_rw),
        .EX_MEM_MemtoReg(o_m2r), .EX_MEM_MemWrite(o_mw), .EX_MEM_MemRead(o_mr),
        .EX_MEM_Branch(o_brn)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".alu"},   o_alu,          e.alu);
        chk({tag, ".zero"},  32'(o_zero),    32'(e.zero));
        chk({tag, ".br"},    o_br,           e.br);
        chk({tag, ".wdata"}, o_wdata,        e.wdata);
        chk({tag, ".rd"},    32'(o_rd),      32'(e.rd));
        chk({tag, ".ctl"},   32'({o_rw, o_m2r, o_mw, o_mr, o_brn}),
                             32'({e.rw, e.m2r, e.mw, e.mr, e.brn}));
    endtask

    function automatic logic [31:0] alu_ref(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a & b;
            5'd3:  return a | b;
            5'd4:  return a ^ b;
            5'd5:  return a << b[4:0];
            5'd6:  return a >> b[4:0];
            5'd7:  return $unsigned($signed(a) >>> b[4:0]);
            5'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd9:  return (a < b) ? 32'd1 : 32'd0;
            5'd10: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] raw);
        if (FWD && cur.rw && !cur.m2r && cur.rd != 5'd0 && cur.rd == rs) return cur.alu;
        if (FWD && wb_rw && wb_rd != 5'd0 && wb_rd == rs) return wb_data;
        return raw;
    endfunction

    function automatic exp_t model_next();
        exp_t n;
        logic [31:0] a, b, bb, res;
        if (fl) return '0;
        if (!wr) return cur;
        a   = fwd(rs1, r1);
        b   = fwd(rs2, r2);
        bb  = c_src ? imm[31:0] : b;
        res = alu_ref(aluop, a, bb);
        n.alu = res; n.zero = (res == 32'd0); n.br = pc + imm[31:0]; n.wdata = b;
        n.rd = rd; n.rw = c_rw; n.m2r = c_m2r; n.mw = c_mw; n.mr = c_mr; n.brn = c_br;
        return n;
    endfunction

    // One clock: push the expected register contents, clock, pop and compare.
    task automatic step(input string tag);
        exp_t e;
        sb_q.push_back(model_next());
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        cur = e;
        chk_all(tag, e);
        $display("step %-10s alu=%h zero=%0d br=%h wdata=%h rd=%0d ctl=%b",
                 tag, o_alu, o_zero, o_br, o_wdata, o_rd, {o_rw, o_m2r, o_mw, o_mr, o_brn});
    endtask

    task automatic instr(input logic [31:0] a_pc, input logic [31:0] a_r1, input logic [31:0] a_r2,
                         input logic [63:0] a_imm, input logic [4:0] a_rs1, input logic [4:0] a_rs2,
                         input logic [4:0] a_rd, input logic [4:0] a_op, input logic [5:0] a_ctl);
        pc = a_pc; r1 = a_r1; r2 = a_r2; imm = a_imm; rs1 = a_rs1; rs2 = a_rs2; rd = a_rd;
        aluop = a_op;
        {c_rw, c_m2r, c_mw, c_mr, c_br, c_src} = a_ctl;
    endtask

    task automatic chk_zero(input string tag);
        chk_all(tag, '0);
    endtask

    initial begin
        rst = 1'b1; wr = 1'b1; fl = 1'b0;
        wb_rw = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        instr(32'd0, 32'd0, 32'd0, 64'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'b000000);
        cur = '0;
        #1;
        chk_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // ADD 5 + 7 -> x3
        instr(32'h40, 32'd5, 32'd7, 64'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000);
        step("add");
        chk("add_lit", o_alu, 32'd12);
        chk("add_zero", 32'(o_zero), 32'd0);

        // SUB x3 - 12: EX forward of 12 gives zero
        instr(32'h44, 32'd0, 32'd12, 64'd0, 5'd3, 5'd5, 5'd6, 5'd1, 6'b100000);
        step("exfwd");
        chk("exfwd_lit", o_alu, FWD ? 32'd0 : 32'hFFFF_FFF4);
        chk("exfwd_zero", 32'(o_zero), FWD ? 32'd1 : 32'd0);

        // Priority: EX/MEM x4=9, MEM/WB x4=2
        instr(32'h48, 32'd4, 32'd5, 64'd0, 5'd1, 5'd2, 5'd4, 5'd0, 6'b100000);
        step("ld_x4");
        instr(32'h4C, 32'd20, 32'd100, 64'd0, 5'd1, 5'd4, 5'd7, 5'd1, 6'b100000);
        wb_rw = 1'b1; wb_rd = 5'd4; wb_data = 32'd2;
        step("prio");
        chk("prio_lit", o_alu, FWD ? 32'd11 : 32'hFFFF_FFB0);
        wb_rw = 1'b0;
        instr(32'h50, 32'd4, 32'd5, 64'd0, 5'd1, 5'd2, 5'd0, 5'd0, 6'b100000);
        step("ld_x0");
        instr(32'h54, 32'd20, 32'd100, 64'd0, 5'd1, 5'd0, 5'd7, 5'd1, 6'b100000);
        wb_rw = 1'b1; wb_rd = 5'd0; wb_data = 32'd2;
        step("x0_nofwd");
        chk("x0_lit", o_alu, 32'hFFFF_FFB0);

        // Load in EX/MEM is not forwarded; MEM/WB supplies x8
        instr(32'h58, 32'd1, 32'd2, 64'd0, 5'd1, 5'd2, 5'd8, 5'd0, 6'b110100);
        wb_rw = 1'b0;
        step("load");
        instr(32'h5C, 32'd3, 32'd0, 64'd16, 5'd8, 5'd8, 5'd9, 5'd0, 6'b100001);
        wb_rw = 1'b1; wb_rd = 5'd8; wb_data = 32'h55;
        step("wbfwd");
        chk("wbfwd_lit", o_alu, FWD ? 32'h65 : 32'h13);
        wb_rw = 1'b0;

        // Stall for two cycles with different inputs presented
        wr = 1'b0;
        instr(32'h60, 32'hAAAA, 32'h5555, 64'd1, 5'd10, 5'd11, 5'd12, 5'd3, 6'b111110);
        step("hold1");
        step("hold2");
        chk("hold_lit", o_alu, FWD ? 32'h65 : 32'h13);
        wr = 1'b1;

        // Flush a store
        instr(32'h64, 32'd1, 32'd2, 64'd4, 5'd1, 5'd2, 5'd9, 5'd0, 6'b101001);
        fl = 1'b1;
        step("flush");
        fl = 1'b0;
        instr(32'h68, 32'd1, 32'd2, 64'd0, 5'd1, 5'd2, 5'd10, 5'd0, 6'b100000);
        step("pre_fl2");
        fl = 1'b1; wr = 1'b0;
        step("flush_hold");
        fl = 1'b0; wr = 1'b1;

        // Branch target, SRA, SLTU, SLT
        instr(32'h100, 32'd3, 32'd3, 64'hFFFF_FFFF_FFFF_FFF8, 5'd1, 5'd2, 5'd0, 5'd1, 6'b000010);
        step("branch");
        chk("br_lit", o_br, 32'h0000_00F8);
        instr(32'h0, 32'h8000_0000, 32'd0, 64'd4, 5'd1, 5'd2, 5'd11, 5'd7, 6'b100001);
        step("sra");
        chk("sra_lit", o_alu, 32'hF800_0000);
        instr(32'h0, 32'd1, 32'hFFFF_FFFF, 64'd0, 5'd1, 5'd2, 5'd12, 5'd9, 6'b100000);
        step("sltu");
        chk("sltu_lit", o_alu, 32'd1);
        aluop = 5'd8;
        step("slt");
        chk("slt_lit", o_alu, 32'd0);

        // Sweep every opcode with random operands and register indices
        for (int i = 0; i < 40; i++) begin
            instr($urandom, $urandom, $urandom, {$urandom, $urandom},
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'(i % 16), 6'($urandom));
            wb_rw = 1'($urandom); wb_rd = 5'($urandom_range(0, 7)); wb_data = $urandom;
            wr = ($urandom_range(0, 4) != 0);
            fl = ($urandom_range(0, 6) == 0);
            step($sformatf("rnd%0d", i));
        end
        wr = 1'b1; fl = 1'b0; wb_rw = 1'b0;

        // Mid-cycle asynchronous reset with nonzero state
        instr(32'h200, 32'd9, 32'd9, 64'd8, 5'd1, 5'd2, 5'd13, 5'd0, 6'b111110);
        step("pre_rst");
        #3;
        rst = 1'b1;
        #1;
        chk_zero("async_rst");
        @(posedge clk);
        #1;
        chk_zero("rst_held");
        rst = 1'b0;
        cur = '0;
        instr(32'h300, 32'd6, 32'd7, 64'd0, 5'd1, 5'd2, 5'd14, 5'd2, 6'b100000);
        step("post_rst");
        chk("post_rst_lit", o_alu, 32'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
